reset_sequencer: RTL

- Multi-channel reset stretcher and release sequencer.
- It merges a global reset, a software reset request and per-channel reset requests. It holds the affected reset outputs for a programmable minimum time, then releases channels one at a time in ascending index order with a programmable gap between releases.
- It sits at the top of each clock domain and drives the resets of its sub-blocks, for example PLL-dependent logic first, then datapath, then bus interfaces. It reports sequence completion on done_o.

---
 rtl/reset_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - multi-channel reset stretcher and ascending release sequencer
module reset_sequencer #(
  parameter int   NUM_CH      = 4,
  parameter int   HOLD_CYCLES = 16,
  parameter int   GAP_CYCLES  = 4,
  parameter logic OUT_POL     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              sw_rst_i,
  input  logic [NUM_CH-1:0] ch_rst_i,
  output logic [NUM_CH-1:0] rst_o,
  output logic              done_o
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int IW      = $clog2(NUM_CH + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_CH   = IW'(NUM_CH - 1);

  // Reject parameter values the counters and index logic cannot represent.
  generate
    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
      $error("reset_sequencer: NUM_CH must be 1..32");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("reset_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("reset_sequencer: GAP_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   m;         // first channel of the current sequence
  logic [IW-1:0]   idx;       // next channel to release while in RELEASE
  logic [CW-1:0]   hold_cnt;
  logic [CW-1:0]   gap_cnt;

  logic            global_req;
  logic            ch_req;
  logic [IW-1:0]   low_idx;
  logic [IW-1:0]   new_m;

  assign global_req = rst_i | sw_rst_i;
  assign ch_req     = |ch_rst_i;

  // Lowest requesting channel; scanning downward leaves the smallest index.
  always_comb begin
    low_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ch_rst_i[k]) begin
        low_idx = IW'(k);
      end
    end
  end

  // Start channel for a request taken this edge: global wins, otherwise the
  // lowest of the running sequence and the new channel request. From DONE the
  // old start channel no longer matters.
  always_comb begin
    new_m = '0;
    if (!global_req) begin
      if (state == ST_DONE || low_idx < m) begin
        new_m = low_idx;
      end else begin
        new_m = m;
      end
    end
  end

  // Sequencer: requests restart the hold, then channels release in order.
  // rst_o holds the output-polarity view of each channel's asserted bit.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rst_o    <= {NUM_CH{OUT_POL}};
      done_o   <= 1'b0;
      state    <= ST_HOLD;
      m        <= '0;
      idx      <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else if (sw_rst_i || ch_req) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (IW'(k) >= new_m) begin
          rst_o[k] <= OUT_POL;
        end
      end
      done_o   <= 1'b0;
      state    <= ST_HOLD;
      m        <= new_m;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (IW'(k) == m) begin
                rst_o[k] <= ~OUT_POL;
              end
            end
            gap_cnt <= '0;
            idx     <= m + IW'(1);
            if (m == LAST_CH) begin
              done_o <= 1'b1;
              state  <= ST_DONE;
            end else begin
              state  <= ST_RELEASE;
            end
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (gap_cnt == GAP_LAST) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (IW'(k) == idx) begin
                rst_o[k] <= ~OUT_POL;
              end
            end
            gap_cnt <= '0;
            idx     <= idx + IW'(1);
            if (idx == LAST_CH) begin
              done_o <= 1'b1;
              state  <= ST_DONE;
            end
          end else begin
            gap_cnt <= gap_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
